// File: rtl/tile_scheduler_if.sv
// Handshake bundle between the tile scheduler and its downstream pair:
// the systolic array (compute_start / compute_done / sta_idle) and the
// output coordinator (oc_done / oc_idle), plus the block geometry both
// of them consume combinationally.
//
// Handshake semantics: compute_start is a level held for exactly the
// ISSUE state (longer only while stalled); the array answers with
// compute_done, which counts only when sta_idle is also high. oc_done is
// held from DRAIN entry until the coordinator drops oc_idle, and the
// writeback is complete when oc_idle returns high. pos_row, pos_col and
// pe_mask stay constant from ISSUE until the cycle that leaves WB.
interface tile_scheduler_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int N_BITS = 10
);
  logic                   compute_start;
  logic                   compute_done;
  logic                   sta_idle;
  logic                   oc_done;
  logic                   oc_idle;
  logic [N_BITS-1:0]      pos_row;
  logic [N_BITS-1:0]      pos_col;
  logic [ROWS*COLS-1:0]   pe_mask;

  // Scheduler side.
  modport master (
    output compute_start, oc_done, pos_row, pos_col, pe_mask,
    input  compute_done, sta_idle, oc_idle
  );

  // Systolic array / output coordinator side.
  modport slave (
    input  compute_start, oc_done, pos_row, pos_col, pe_mask,
    output compute_done, sta_idle, oc_idle
  );
endinterface

// File: rtl/tile_scheduler.sv
// Walks a mat_rows x mat_cols output matrix block by block (row-major),
// issuing one compute per block to the systolic array and one writeback
// to the output coordinator, then pulses layer_done. Partial edge blocks
// get a per-PE active mask. All control outputs are Moore decodes of the
// state register.
module tile_scheduler #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int MAX_N  = 512,
  parameter int N_BITS = $clog2(MAX_N + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              start,
  input  logic [N_BITS-1:0] mat_rows,
  input  logic [N_BITS-1:0] mat_cols,
  output logic              busy,
  output logic              layer_done,
  output logic [2:0]        dbg_state,
  tile_scheduler_if.master  sif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_WB      = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  // One extra bit so pos + step never wraps near MAX_N.
  localparam int EXT_W = N_BITS + 1;
  localparam logic [EXT_W-1:0] ROWS_EXT = EXT_W'(ROWS);
  localparam logic [EXT_W-1:0] COLS_EXT = EXT_W'(COLS);

  state_t            state_q, state_d;
  logic [N_BITS-1:0] rows_q, rows_d;
  logic [N_BITS-1:0] cols_q, cols_d;
  logic [N_BITS-1:0] pos_row_q, pos_row_d;
  logic [N_BITS-1:0] pos_col_q, pos_col_d;

  logic [EXT_W-1:0]  next_col_ext;
  logic [EXT_W-1:0]  next_row_ext;
  logic [ROWS*COLS-1:0] pe_mask_c;

  assign next_col_ext = {1'b0, pos_col_q} + COLS_EXT;
  assign next_row_ext = {1'b0, pos_row_q} + ROWS_EXT;

  // State and block-position registers; stall is folded into the _d terms.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      pos_row_q <= '0;
      pos_col_q <= '0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      pos_row_q <= pos_row_d;
      pos_col_q <= pos_col_d;
    end
  end

  // Next-state and traversal: everything holds unless explicitly advanced.
  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    pos_row_d = pos_row_q;
    pos_col_d = pos_col_q;
    if (!stall) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rows_d    = mat_rows;
            cols_d    = mat_cols;
            pos_row_d = '0;
            pos_col_d = '0;
            if (mat_rows == '0 || mat_cols == '0) state_d = S_FINISH;
            else                                  state_d = S_ISSUE;
          end
        end
        S_ISSUE: state_d = S_COMPUTE;
        S_COMPUTE: begin
          if (sif.compute_done && sif.sta_idle) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          // Coordinator has taken the block once it leaves idle.
          if (!sif.oc_idle) state_d = S_WB;
        end
        S_WB: begin
          if (sif.oc_idle) begin
            if (next_col_ext < {1'b0, cols_q}) begin
              pos_col_d = next_col_ext[N_BITS-1:0];
              state_d   = S_ISSUE;
            end else if (next_row_ext < {1'b0, rows_q}) begin
              pos_col_d = '0;
              pos_row_d = next_row_ext[N_BITS-1:0];
              state_d   = S_ISSUE;
            end else begin
              state_d = S_FINISH;
            end
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Per-PE active mask for the current block; all-zero while idle.
  always_comb begin
    pe_mask_c = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        pe_mask_c[i*COLS+j] = busy &&
          (({1'b0, pos_row_q} + EXT_W'(i)) < {1'b0, rows_q}) &&
          (({1'b0, pos_col_q} + EXT_W'(j)) < {1'b0, cols_q});
      end
    end
  end

  assign busy              = (state_q != S_IDLE);
  assign layer_done        = (state_q == S_FINISH);
  assign sif.compute_start = (state_q == S_ISSUE);
  assign sif.oc_done       = (state_q == S_DRAIN);
  assign sif.pos_row       = pos_row_q;
  assign sif.pos_col       = pos_col_q;
  assign sif.pe_mask       = pe_mask_c;
  assign dbg_state         = state_q;

endmodule
